// File: rtl/neural_data_loader.sv
// Layer load stage: streams layer_words memory words starting at layer_base_addr into the
// layer input FIFO, then raises data_loaded until the control FSM drops begin_load_data.
module neural_data_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              begin_load_data,
  input  logic [7:0]        stage,
  input  logic [ADDR_W-1:0] layer_base_addr,
  input  logic [CNT_W-1:0]  layer_words,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_full,
  output logic              data_loaded,
  output logic [7:0]        loaded_stage,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    words_q;
  logic [CNT_W-1:0]    issued_q;
  logic                rd_pending_q;
  logic                hold_valid_q;
  logic [DATA_W-1:0]   hold_data_q;

  logic                active;
  logic                issue;
  logic                push;
  logic                capture;
  logic [CNT_W-1:0]    pushed_nxt;

  // Handshakes: begin_load_data/data_loaded is four-phase (request level, done held until
  // request falls); a FIFO push happens on any cycle fifo_wr_en=1 and fifo_full=0; read data
  // is valid exactly one cycle after mem_rd_en.
  always_comb begin
    active     = ((state == LOAD) || (state == DRAIN)) && begin_load_data;
    issue      = (state == LOAD) && begin_load_data && (issued_q < words_q) &&
                 !fifo_full && !hold_valid_q;
    push       = active && (hold_valid_q || rd_pending_q) && !fifo_full;
    capture    = active && rd_pending_q && !hold_valid_q && fifo_full;
    pushed_nxt = words_loaded + CNT_W'(push);

    mem_rd_en  = issue;
    mem_addr   = issue ? (base_q + ADDR_W'(issued_q)) : '0;
    fifo_wr_en = push;
    fifo_wdata = push ? (hold_valid_q ? hold_data_q : mem_rdata) : '0;
    state_dbg  = state;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (begin_load_data) state_nxt = (layer_words == '0) ? DONE : LOAD;
      LOAD:
        if (!begin_load_data) state_nxt = IDLE;
        else if (issue && (issued_q == words_q - 1'b1)) state_nxt = DRAIN;
      DRAIN:
        if (!begin_load_data) state_nxt = IDLE;
        else if (pushed_nxt == words_q) state_nxt = DONE;
      DONE:
        if (!begin_load_data) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base_q       <= '0;
      words_q      <= '0;
      issued_q     <= '0;
      rd_pending_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      data_loaded  <= 1'b0;
      loaded_stage <= '0;
      words_loaded <= '0;
    end else begin
      state        <= state_nxt;
      rd_pending_q <= issue;
      data_loaded  <= (state == DONE) && begin_load_data;

      if ((state == IDLE) && begin_load_data) begin
        base_q       <= layer_base_addr;
        words_q      <= layer_words;
        loaded_stage <= stage;
        issued_q     <= '0;
        words_loaded <= '0;
        hold_valid_q <= 1'b0;
      end else begin
        if (issue) issued_q <= issued_q + 1'b1;
        if (push) words_loaded <= pushed_nxt;
        // Leaving LOAD/DRAIN for any reason discards a word parked in the holding register.
        if (!active) hold_valid_q <= 1'b0;
        else if (capture) begin
          hold_valid_q <= 1'b1;
          hold_data_q  <= mem_rdata;
        end else if (push && hold_valid_q) hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neural_data_loader.sv
// Self-checking bench for neural_data_loader: table-driven loads, FIFO back-pressure,
// abort, address wrap, reset mid-load and randomized back-pressure against a queue model.
module tb_neural_data_loader;

  logic        clk;
  logic        reset;
  logic        begin_load_data;
  logic [7:0]  stage;
  logic [15:0] layer_base_addr;
  logic [15:0] layer_words;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        fifo_wr_en;
  logic [31:0] fifo_wdata;
  logic        fifo_full;
  logic        data_loaded;
  logic [7:0]  loaded_stage;
  logic [15:0] words_loaded;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  logic [15:0] rd_q[$];
  logic [31:0] got_q[$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] words;
    logic [7:0]  stg;
    int          exp_lat;
  } vec_t;

  neural_data_loader dut (
    .clk(clk), .reset(reset), .begin_load_data(begin_load_data), .stage(stage),
    .layer_base_addr(layer_base_addr), .layer_words(layer_words),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .data_loaded(data_loaded), .loaded_stage(loaded_stage), .words_loaded(words_loaded),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3C3, a};
  endfunction

  // Memory: one-cycle read latency, junk on the bus when no read was issued.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word(mem_addr) : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: records read addresses and FIFO pushes, flags traffic while the FIFO is full.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin
        rd_q.push_back(mem_addr);
        check("rd_while_full", fifo_full, 1'b0);
      end
      if (fifo_wr_en) begin
        got_q.push_back(fifo_wdata);
        check("push_while_full", fifo_full, 1'b0);
      end
    end
  end

  // driver + scoreboard for one complete load
  task automatic run_load(input logic [15:0] base, input logic [15:0] words, input logic [7:0] stg,
                          input int exp_lat, input int ff_lo, input int ff_hi, input bit rnd);
    int lat;
    bit timeout;
    logic [15:0] a;
    @(posedge clk); #1;
    layer_base_addr = base;
    layer_words     = words;
    stage           = stg;
    fifo_full       = 1'b0;
    begin_load_data = 1'b1;
    rd_q.delete();
    got_q.delete();
    lat = 0;
    timeout = 1'b0;
    forever begin
      @(negedge clk);
      if (data_loaded) break;
      lat++;
      if (lat > 4 * int'(words) + 60) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      fifo_full = ((lat >= ff_lo) && (lat < ff_hi)) || (rnd && ($urandom_range(0, 3) == 0));
    end
    check("load_timeout", timeout, 1'b0);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    check("words_loaded", words_loaded, words);
    check("loaded_stage", loaded_stage, stg);
    check("read_count", rd_q.size(), words);
    check("push_count", got_q.size(), words);
    for (int i = 0; i < int'(words); i++) begin
      a = base + 16'(i);
      if (i < rd_q.size()) check("read_addr", rd_q[i], a);
      if (i < got_q.size()) check("push_data", got_q[i], mem_word(a));
    end
    @(posedge clk); #1;
    fifo_full       = 1'b0;
    begin_load_data = 1'b0;
    @(negedge clk);
    check("dl_held", data_loaded, 1'b1);
    @(negedge clk);
    check("dl_cleared", data_loaded, 1'b0);
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{base: 16'h0100, words: 16'd4,  stg: 8'd1, exp_lat: 7};
    vt[1] = '{base: 16'h0200, words: 16'd0,  stg: 8'd2, exp_lat: 2};
    vt[2] = '{base: 16'hFFFE, words: 16'd4,  stg: 8'd3, exp_lat: 7};
    vt[3] = '{base: 16'h1234, words: 16'd1,  stg: 8'd4, exp_lat: 4};
    vt[4] = '{base: 16'h0FF0, words: 16'd17, stg: 8'd9, exp_lat: 20};

    reset = 1'b0;
    begin_load_data = 1'b0;
    stage = '0;
    layer_base_addr = '0;
    layer_words = '0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_fifo_wr_en", fifo_wr_en, 1'b0);
    check("rst_data_loaded", data_loaded, 1'b0);
    check("rst_words_loaded", words_loaded, 16'd0);
    check("rst_loaded_stage", loaded_stage, 8'd0);
    check("rst_mem_addr", mem_addr, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 5; i++)
      run_load(vt[i].base, vt[i].words, vt[i].stg, vt[i].exp_lat, 0, 0, 1'b0);

    // FIFO full for three cycles mid-load
    run_load(16'h0600, 16'd6, 8'd3, -1, 3, 6, 1'b0);

    // abort after two reads, then a clean load
    @(posedge clk); #1;
    layer_base_addr = 16'h2000;
    layer_words     = 16'd8;
    stage           = 8'd5;
    begin_load_data = 1'b1;
    rd_q.delete();
    got_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    begin_load_data = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_dl", data_loaded, 1'b0);
    end
    check("abort_reads", rd_q.size(), 2);
    check("abort_pushes", got_q.size(), 1);
    if (got_q.size() > 0) check("abort_data", got_q[0], mem_word(16'h2000));
    run_load(16'h3000, 16'd3, 8'd6, 6, 0, 0, 1'b0);

    // reset during LOAD
    @(posedge clk); #1;
    layer_base_addr = 16'h4000;
    layer_words     = 16'd10;
    stage           = 8'd7;
    begin_load_data = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst_mem_rd_en", mem_rd_en, 1'b0);
    check("arst_mem_addr", mem_addr, 16'd0);
    check("arst_fifo_wr_en", fifo_wr_en, 1'b0);
    check("arst_fifo_wdata", fifo_wdata, 32'd0);
    check("arst_words_loaded", words_loaded, 16'd0);
    check("arst_loaded_stage", loaded_stage, 8'd0);
    check("arst_data_loaded", data_loaded, 1'b0);
    begin_load_data = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    run_load(16'h5000, 16'd5, 8'd2, 8, 0, 0, 1'b0);

    // randomized back-pressure
    for (int i = 0; i < 8; i++)
      run_load(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 20)),
               8'($urandom_range(1, 255)), -1, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
